// File: rtl/pontos_pkg.sv
// Shared definitions for the team float datapath.
// Format: 1 sign | 6 exp (bias 31) | 25 mantissa, hidden 1.
package pontos_pkg;

  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;
  localparam int BIAS   = 31;
  localparam int INT_W  = 32;
  localparam int SIG_W  = MANT_W + 1;
  localparam int FLT_W  = 1 + EXP_W + MANT_W;
  localparam int CNT_W  = 5;
  localparam int ST_W   = 4;

  localparam int ST_EXACT     = 3;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 1;
  localparam int ST_INEXACT   = 0;

  localparam logic [ST_W-1:0] STAT_EXACT = ST_W'(1 << ST_EXACT);
  localparam logic [ST_W-1:0] STAT_OVF   = ST_W'(1 << ST_OVERFLOW);
  localparam logic [ST_W-1:0] STAT_UNF   = ST_W'(1 << ST_UNDERFLOW);
  localparam logic [ST_W-1:0] STAT_INEX  = ST_W'(1 << ST_INEXACT);

  // exponent where the significand lsb has weight 1
  localparam logic [EXP_W-1:0] E_UNIT = EXP_W'(BIAS + MANT_W);
  // first exponent whose value cannot fit a positive int
  localparam logic [EXP_W-1:0] E_SAT  = EXP_W'(BIAS + INT_W - 1);
  // smallest exponent with magnitude >= 1
  localparam logic [EXP_W-1:0] E_MIN  = EXP_W'(BIAS);

  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_NEG   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float_t;

endpackage

// File: rtl/float_to_int_converter_if.sv
// Request/result bundle of the float-to-int converter.
// master = requester, slave = converter.
interface float_to_int_converter_if;
  import pontos_pkg::*;

  logic             start;
  logic [FLT_W-1:0] float_in;
  logic             busy;
  logic             done;
  logic [INT_W-1:0] int_out;
  logic [ST_W-1:0]  status_out;
  logic [2:0]       qual_lugar;

  modport master (
    output start, float_in,
    input  busy, done, int_out, status_out, qual_lugar
  );

  modport slave (
    input  start, float_in,
    output busy, done, int_out, status_out, qual_lugar
  );

endinterface

// File: rtl/fp_unpack.sv
// Field split and classification of a team float.
// Flags the operands that never reach the shifter.
module fp_unpack
  import pontos_pkg::*;
(
  input  float_t           f,
  output logic [SIG_W-1:0] sig,
  output logic             is_zero,
  output logic             is_under,
  output logic             is_over,
  output logic             is_min_neg
);

  // classify by exponent range; E=0 with a mantissa is underflow
  always_comb begin
    sig        = {1'b1, f.mant};
    is_zero    = (f.exp == '0) && (f.mant == '0);
    is_under   = !is_zero && (f.exp < E_MIN);
    is_over    = (f.exp >= E_SAT);
    is_min_neg = f.sign && (f.exp == E_SAT) && (f.mant == '0);
  end

endmodule

// File: rtl/float_to_int_converter.sv
// Serial float-to-int converter, truncating toward zero.
// Shifts one bit per cycle, then applies the sign.
module float_to_int_converter
  import pontos_pkg::*;
(
  input  logic                      clock_100kHz,
  input  logic                      reset,
  float_to_int_converter_if.slave   bus
);

  state_t            state_q, state_d;
  float_t            op_q, op_d;
  logic [INT_W-1:0]  mag_q, mag_d;
  logic              sticky_q, sticky_d;
  logic              left_q, left_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [INT_W-1:0]  int_out_q, int_out_d;
  logic [ST_W-1:0]   status_q, status_d;

  logic [SIG_W-1:0]  sig;
  logic              is_zero, is_under, is_over, is_min_neg;
  logic              special;
  logic              ld_left;
  logic [CNT_W-1:0]  ld_cnt;

  fp_unpack u_unpack (
    .f          (op_q),
    .sig        (sig),
    .is_zero    (is_zero),
    .is_under   (is_under),
    .is_over    (is_over),
    .is_min_neg (is_min_neg)
  );

  // shift direction and distance for the captured operand
  always_comb begin
    special = is_zero || is_under || is_over;
    ld_left = (op_q.exp >= E_UNIT);
    ld_cnt  = ld_left ? CNT_W'(op_q.exp - E_UNIT)
                      : CNT_W'(E_UNIT - op_q.exp);
  end

  // state and datapath registers
  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      mag_q     <= '0;
      sticky_q  <= 1'b0;
      left_q    <= 1'b0;
      n_q       <= '0;
      int_out_q <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mag_q     <= mag_d;
      sticky_q  <= sticky_d;
      left_q    <= left_d;
      n_q       <= n_d;
      int_out_q <= int_out_d;
      status_q  <= status_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD: begin
        if (special)          state_d = S_DONE;
        else if (ld_cnt == '0) state_d = S_NEG;
        else                  state_d = S_SHIFT;
      end
      S_SHIFT: if (n_q == CNT_W'(1)) state_d = S_NEG;
      S_NEG:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // capture, shift, sign and result registration
  always_comb begin
    op_d      = op_q;
    mag_d     = mag_q;
    sticky_d  = sticky_q;
    left_d    = left_q;
    n_d       = n_q;
    int_out_d = int_out_q;
    status_d  = status_q;
    unique case (state_q)
      S_IDLE: if (bus.start) op_d = bus.float_in;
      S_LOAD: begin
        mag_d    = INT_W'(sig);
        sticky_d = 1'b0;
        left_d   = ld_left;
        n_d      = ld_cnt;
        if (is_zero) begin
          int_out_d = '0;
          status_d  = STAT_EXACT;
        end else if (is_under) begin
          int_out_d = '0;
          status_d  = STAT_UNF;
        end else if (is_min_neg) begin
          int_out_d = INT_MIN;
          status_d  = STAT_EXACT;
        end else if (is_over) begin
          int_out_d = op_q.sign ? INT_MIN : INT_MAX;
          status_d  = STAT_OVF;
        end
      end
      S_SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          sticky_d = sticky_q | mag_q[0];
        end
        n_d = n_q - CNT_W'(1);
      end
      S_NEG: begin
        int_out_d = op_q.sign ? -mag_q : mag_q;
        status_d  = sticky_q ? STAT_INEX : STAT_EXACT;
      end
      default: ;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    bus.busy       = (state_q != S_IDLE);
    bus.done       = (state_q == S_DONE);
    bus.qual_lugar = state_q;
    bus.int_out    = int_out_q;
    bus.status_out = status_q;
  end

endmodule

// File: tb/tb_float_to_int_converter.sv
// Bench for float_to_int_converter: vector table,
// scoreboard, and control corner sequences.
module tb_float_to_int_converter;

  typedef struct {
    logic [31:0] f;
    logic [31:0] want_int;
    logic [3:0]  want_st;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] i;
    logic [3:0]  s;
    int          lat;
  } exp_t;

  localparam logic [3:0] EX = 4'b1000;
  localparam logic [3:0] OV = 4'b0100;
  localparam logic [3:0] UN = 4'b0010;
  localparam logic [3:0] IN = 4'b0001;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   done_cnt;
  exp_t sb[$];
  vec_t vecs[16];

  float_to_int_converter_if bus();

  float_to_int_converter dut (
    .clock_100kHz (clk),
    .reset        (rst_n),
    .bus          (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic run_vec(input vec_t v, input int poke);
    int   cyc;
    bit   got;
    exp_t e;
    sb.push_back('{v.want_int, v.want_st, v.lat});
    @(negedge clk);
    bus.float_in = v.f;
    bus.start    = 1'b1;
    @(posedge clk);
    cyc = 1;
    got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      bus.float_in = $urandom;
      bus.start    = (cyc == poke);
      if (bus.done === 1'b1) got = 1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout f=%h got=none want=cycle %0d", v.f, e.lat);
    end else begin
      chk($sformatf("int_out f=%h", v.f), bus.int_out, e.i);
      chk($sformatf("status f=%h", v.f), 32'(bus.status_out), 32'(e.s));
      chk($sformatf("latency f=%h", v.f), cyc, e.lat);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk($sformatf("idle_after f=%h", v.f),
        {bus.done, bus.busy, bus.qual_lugar}, 32'h0);
  endtask

  initial begin
    int d0;
    vec_t v;
    checks   = 0;
    failures = 0;
    done_cnt = 0;

    vecs[0]  = '{32'h3E000000, 32'h00000001, EX, 28};
    vecs[1]  = '{32'h40000000, 32'h00000002, EX, 27};
    vecs[2]  = '{32'hC0800000, 32'hFFFFFFFE, IN, 27};
    vecs[3]  = '{32'h3C000000, 32'h00000000, UN, 2};
    vecs[4]  = '{32'h00000000, 32'h00000000, EX, 2};
    vecs[5]  = '{32'h7C000000, 32'h7FFFFFFF, OV, 2};
    vecs[6]  = '{32'hFC000000, 32'h80000000, EX, 2};
    vecs[7]  = '{32'h7E000000, 32'h7FFFFFFF, OV, 2};
    vecs[8]  = '{32'h70000000, 32'h02000000, EX, 3};
    vecs[9]  = '{32'h7BFFFFFF, 32'h7FFFFFE0, EX, 8};
    vecs[10] = '{32'hFBFFFFFF, 32'h80000020, EX, 8};
    vecs[11] = '{32'h00000001, 32'h00000000, UN, 2};
    vecs[12] = '{32'h3FFFFFFF, 32'h00000001, IN, 28};
    vecs[13] = '{32'h80000000, 32'h00000000, EX, 2};
    vecs[14] = '{32'hFC000001, 32'h80000000, OV, 2};
    vecs[15] = '{32'hEE000001, 32'hFF000000, IN, 4};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.float_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_int_out", bus.int_out, 32'h0);
    chk("rst_status", 32'(bus.status_out), 32'h0);
    chk("rst_state", 32'(bus.qual_lugar), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[k]) run_vec(vecs[k], 0);

    // second start during SHIFT must not queue a conversion
    d0 = done_cnt;
    run_vec(vecs[0], 6);
    repeat (40) @(negedge clk);
    chk("single_done_shift_poke", done_cnt - d0, 1);

    // start held in the DONE cycle must be ignored
    run_vec(vecs[1], 27);
    repeat (40) @(negedge clk);
    chk("no_done_after_done_poke", done_cnt - d0, 2);

    // asynchronous reset in the middle of SHIFT
    @(negedge clk);
    bus.float_in = 32'h3E000000;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("in_shift_state", 32'(bus.qual_lugar), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(bus.qual_lugar), 32'h0);
    chk("midrst_int_out", bus.int_out, 32'h0);
    chk("midrst_status", 32'(bus.status_out), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_idle", 32'(bus.qual_lugar), 32'h0);

    v = vecs[2];
    run_vec(v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
